interpolate_audio_out: RTL

- Output-side counterpart of the mic input chain: accepts processed audio at 24 kHz and produces 2x linearly interpolated samples at 48 kHz for the DAC/speaker path.
- Re-applies a DC offset with saturation.
- Buffers input in a small FIFO behind a valid/ready handshake; emits exactly one sample per 48 kHz DAC trigger.

---
 rtl/audio_pkg.sv | 19 +
 rtl/sample_fifo.sv | 57 +++++
 rtl/interpolate_audio_out.sv | 104 ++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types, widths and saturation helper for the audio output path
package audio_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [0:0] {
        EMIT_MID = 1'b0,
        EMIT_CUR = 1'b1
    } emit_state_t;

    // 17-bit sums of two 16-bit values only overflow by one bit, so a sign-bit compare suffices.
    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SAMPLE_W:0] x);
        if (x[SAMPLE_W] != x[SAMPLE_W-1]) begin
            return x[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end
        return x[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous power-of-two FIFO with head-of-queue data and occupancy level
module sample_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;

    // Storage needs no reset; the pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                r_level <= r_level + LW'(1);
            end else if (pop && !push) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign level = r_level;
    assign full  = (r_level == LW'(DEPTH));
    assign empty = (r_level == '0);

endmodule

// File: rtl/interpolate_audio_out.sv
// rtl/interpolate_audio_out.sv - 24 kHz to 48 kHz linear interpolator with DC offset and saturation
module interpolate_audio_out
    import audio_pkg::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int UNDERFLOW_CNT_W = 8
) (
    input  logic                              audio_clk,
    input  logic                              rst_in_n,
    input  logic signed [SAMPLE_W-1:0]        sample_in,
    input  logic                              sample_in_valid,
    output logic                              sample_in_ready,
    input  logic                              dac_trigger,
    input  logic signed [SAMPLE_W-1:0]        offset_in,
    input  logic                              mute_in,
    output logic signed [SAMPLE_W-1:0]        audio_out,
    output logic                              audio_out_valid,
    output logic                              underflow,
    output logic [UNDERFLOW_CNT_W-1:0]        underflow_count,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

    emit_state_t                 r_state;
    logic signed [SAMPLE_W-1:0]  r_cur;
    logic signed [SAMPLE_W-1:0]  r_audio_out;
    logic                        r_audio_out_valid;
    logic                        r_underflow;
    logic [UNDERFLOW_CNT_W-1:0]  r_underflow_count;

    logic                        w_push;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_ready;
    logic                        w_at_mid;
    logic                        w_underflow;
    logic [SAMPLE_W-1:0]         w_head;
    logic signed [SAMPLE_W:0]    w_pair_sum;
    logic signed [SAMPLE_W-1:0]  w_v;
    logic signed [SAMPLE_W-1:0]  w_v_muted;
    logic signed [SAMPLE_W:0]    w_out_sum;

    sample_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (SAMPLE_W)
    ) u_sample_fifo (
        .clk       (audio_clk),
        .rst_n     (rst_in_n),
        .push      (w_push),
        .push_data (sample_in),
        .pop       (w_pop),
        .head      (w_head),
        .level     (fifo_level),
        .full      (w_full),
        .empty     (w_empty)
    );

    // Ready comes only from the registered level so a same-cycle pop never opens a slot early.
    assign w_ready     = !w_full;
    assign w_push      = sample_in_valid && w_ready;
    assign w_at_mid    = (r_state == EMIT_MID);
    assign w_pop       = dac_trigger && w_at_mid && !w_empty;
    assign w_underflow = dac_trigger && w_at_mid && w_empty;

    always_comb begin
        w_pair_sum = {r_cur[SAMPLE_W-1], r_cur} + {w_head[SAMPLE_W-1], w_head};
        w_v        = w_pop ? w_pair_sum[SAMPLE_W:1] : r_cur;
        w_v_muted  = mute_in ? '0 : w_v;
        w_out_sum  = {w_v_muted[SAMPLE_W-1], w_v_muted} + {offset_in[SAMPLE_W-1], offset_in};
    end

    always_ff @(posedge audio_clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_state           <= EMIT_MID;
            r_cur             <= '0;
            r_audio_out       <= '0;
            r_audio_out_valid <= 1'b0;
            r_underflow       <= 1'b0;
            r_underflow_count <= '0;
        end else begin
            r_audio_out_valid <= dac_trigger;
            r_underflow       <= w_underflow;
            if (dac_trigger) begin
                r_audio_out <= sat16(w_out_sum);
                if (w_pop) begin
                    r_cur   <= w_head;
                    r_state <= EMIT_CUR;
                end else if (!w_at_mid) begin
                    r_state <= EMIT_MID;
                end
            end
            if (w_underflow && (r_underflow_count != '1)) begin
                r_underflow_count <= r_underflow_count + UNDERFLOW_CNT_W'(1);
            end
        end
    end

    assign sample_in_ready = w_ready;
    assign audio_out       = r_audio_out;
    assign audio_out_valid = r_audio_out_valid;
    assign underflow       = r_underflow;
    assign underflow_count = r_underflow_count;

endmodule
